// File: rtl/hwt_sweep_ctrl.sv
// Exhaustive 16-vector sweep of a 4-input hwt cell: drives A..D, waits a
// programmable settle time per vector, captures Y and compares it to a golden table.
module hwt_sweep_ctrl #(
    parameter int SETTLE_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle,
    input  logic [15:0]         golden,
    output logic                hwt_a,
    output logic                hwt_b,
    output logic                hwt_c,
    output logic                hwt_d,
    input  logic                hwt_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         truth,
    output logic [4:0]          mismatch_cnt,
    output logic [3:0]          first_fail,
    output logic                first_fail_vld
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

    state_t              state_q, state_d;
    logic [3:0]          v_q, v_d;
    logic [3:0]          vec_q, vec_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [15:0]         golden_q, golden_d;
    logic [15:0]         truth_q, truth_d;
    logic [4:0]          mm_q, mm_d;
    logic [3:0]          ff_q, ff_d;
    logic                ffv_q, ffv_d;
    logic                pass_q, pass_d;
    logic                miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            v_q      <= '0;
            vec_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            golden_q <= '0;
            truth_q  <= '0;
            mm_q     <= '0;
            ff_q     <= '0;
            ffv_q    <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            golden_q <= golden_d;
            truth_q  <= truth_d;
            mm_q     <= mm_d;
            ff_q     <= ff_d;
            ffv_q    <= ffv_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        golden_d = golden_q;
        truth_d  = truth_q;
        mm_d     = mm_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        pass_d   = pass_q;
        miss     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    v_d      = '0;
                    settle_d = settle;
                    golden_d = golden;
                    truth_d  = '0;
                    mm_d     = '0;
                    ff_d     = '0;
                    ffv_d    = 1'b0;
                    pass_d   = 1'b0;
                    cnt_d    = settle - SETTLE_W'(1);
                    state_d  = (settle == '0) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    truth_d[v_q] = hwt_y;
                    miss = (hwt_y != golden_q[v_q]);
                    if (miss) begin
                        mm_d = mm_q + 5'd1;
                        if (!ffv_q) begin
                            ff_d  = v_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (v_q == 4'd15) begin
                        // pass must include the final sample, so use the updated count
                        state_d = FINISH;
                        pass_d  = (mm_d == 5'd0);
                    end else begin
                        v_d     = v_q + 4'd1;
                        cnt_d   = settle_q - SETTLE_W'(1);
                        state_d = (settle_q == '0) ? SAMPLE : SETTLE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Cell inputs are registered and follow the vector only while the sweep drives them
        vec_d = ((state_d == SETTLE) || (state_d == SAMPLE)) ? v_d : 4'd0;
    end

    assign hwt_a          = vec_q[3];
    assign hwt_b          = vec_q[2];
    assign hwt_c          = vec_q[1];
    assign hwt_d          = vec_q[0];
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FINISH);
    assign pass           = pass_q;
    assign truth          = truth_q;
    assign mismatch_cnt   = mm_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_hwt_sweep_ctrl.sv
// Self-checking bench for hwt_sweep_ctrl: bench-side hwt cell variants, an
// arithmetic timeline model checked every cycle, and literal expectations.
module tb_hwt_sweep_ctrl;

    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] settle = '0;
    logic [15:0]   golden = '0;
    logic          hwt_a, hwt_b, hwt_c, hwt_d, hwt_y;
    logic          busy, done, pass;
    logic [15:0]   truth;
    logic [4:0]    mismatch_cnt;
    logic [3:0]    first_fail;
    logic          first_fail_vld;

    int checks = 0;
    int errors = 0;

    // Cell kinds: 0 = ideal hwt, 1 = stuck at 0, 2 = hwt with 2-cycle delay, 3 = random table
    int          cell_kind = 0;
    logic [15:0] tbl = '0;
    logic [3:0]  vec;
    logic [3:0]  p1 = '0;
    logic [3:0]  p2 = '0;

    always #5 clk = ~clk;

    hwt_sweep_ctrl #(.SETTLE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .settle(settle), .golden(golden),
        .hwt_a(hwt_a), .hwt_b(hwt_b), .hwt_c(hwt_c), .hwt_d(hwt_d),
        .hwt_y(hwt_y), .busy(busy), .done(done), .pass(pass),
        .truth(truth), .mismatch_cnt(mismatch_cnt),
        .first_fail(first_fail), .first_fail_vld(first_fail_vld)
    );

    function automatic logic gold_y(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (c | (a & b)) & d & ~(a & b & c);
    endfunction

    assign vec = {hwt_a, hwt_b, hwt_c, hwt_d};

    always @(posedge clk) begin
        p1 <= vec;
        p2 <= p1;
    end

    always_comb begin
        hwt_y = 1'b0;
        case (cell_kind)
            0:       hwt_y = gold_y(vec);
            1:       hwt_y = 1'b0;
            2:       hwt_y = gold_y(p2);
            default: hwt_y = tbl[vec];
        endcase
    end

    // Y the sweep must see for each vector: vector v is sampled in sweep cycle (v+1)(s+1)-1;
    // the delayed cell shows the vector from two cycles earlier (idle before the sweep = 0).
    function automatic logic [15:0] full_truth(input int kind, input int s, input logic [15:0] t);
        logic [15:0] r;
        int kk;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            case (kind)
                0: r[v] = gold_y(4'(v));
                1: r[v] = 1'b0;
                2: begin
                    kk = (v + 1) * (s + 1) - 3;
                    r[v] = gold_y(kk < 0 ? 4'd0 : 4'(kk / (s + 1)));
                end
                default: r[v] = t[v];
            endcase
        end
        return r;
    endfunction

    function automatic void results(input int n, input logic [15:0] ft, input logic [15:0] g,
                                    output logic [15:0] et, output int em, output int ef,
                                    output logic efv);
        et = '0; em = 0; ef = 0; efv = 1'b0;
        for (int v = 0; v < n; v++) begin
            et[v] = ft[v];
            if (ft[v] != g[v]) begin
                em++;
                if (!efv) begin
                    ef  = v;
                    efv = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a sweep is a timeline of 16*(s+1) cycles counted from the accepted start edge
    logic        m_run = 1'b0;
    int          m_k = 0;
    int          m_s = 0;
    int          m_n = 0;
    logic        m_pass = 1'b0;
    logic [15:0] m_g = '0;
    logic [15:0] m_ft = '0;

    always @(posedge clk) begin
        logic [15:0] t_et;
        int t_em, t_ef;
        logic t_efv;
        if (rst) begin
            m_run = 1'b0; m_n = 0; m_pass = 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1'b1; m_k = 0; m_s = int'(settle); m_g = golden;
                m_ft = full_truth(cell_kind, int'(settle), tbl);
                m_n = 0; m_pass = 1'b0;
            end
        end else if (m_k < 16 * (m_s + 1) && abort) begin
            m_run = 1'b0; m_n = m_k / (m_s + 1); m_pass = 1'b0;
        end else begin
            m_k++;
            if (m_k > 16 * (m_s + 1)) begin
                m_run = 1'b0; m_n = 16;
                results(16, m_ft, m_g, t_et, t_em, t_ef, t_efv);
                m_pass = (t_em == 0);
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] c_et;
        int c_em, c_ef, c_n, c_per;
        logic c_efv, c_busy, c_done, c_pass, c_fin;
        logic [3:0] c_vec;
        if (rst) begin
            c_et = '0; c_em = 0; c_ef = 0; c_efv = 1'b0;
            c_busy = 1'b0; c_done = 1'b0; c_pass = 1'b0; c_vec = '0;
        end else if (m_run) begin
            c_per  = m_s + 1;
            c_fin  = (m_k == 16 * c_per);
            c_n    = c_fin ? 16 : m_k / c_per;
            c_busy = 1'b1;
            c_done = c_fin;
            c_vec  = c_fin ? 4'd0 : 4'(m_k / c_per);
            results(c_n, m_ft, m_g, c_et, c_em, c_ef, c_efv);
            c_pass = c_fin && (c_em == 0);
        end else begin
            c_busy = 1'b0; c_done = 1'b0; c_vec = '0; c_pass = m_pass;
            results(m_n, m_ft, m_g, c_et, c_em, c_ef, c_efv);
        end
        chk("busy", 32'(busy), 32'(c_busy));
        chk("done", 32'(done), 32'(c_done));
        chk("pass", 32'(pass), 32'(c_pass));
        chk("hwt_vec", 32'(vec), 32'(c_vec));
        chk("truth", 32'(truth), 32'(c_et));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(c_em));
        chk("first_fail_vld", 32'(first_fail_vld), 32'(c_efv));
        chk("first_fail", 32'(first_fail), 32'(c_ef));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_sweep(input int kind, input int s, input logic [15:0] g, input logic [15:0] t);
        cell_kind = kind; tbl = t; settle = SW'(s); golden = g;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_sweep(input int kind, input int s, input logic [15:0] g,
                             input logic [15:0] t, input bit noise, output int lat);
        begin_sweep(kind, s, g, t);
        lat = 1;
        while (!done && lat < 1000) begin
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                settle = SW'($urandom);
                golden = 16'($urandom);
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_vec(input logic [3:0] target);
        int n;
        n = 0;
        while (vec != target && n < 200) begin
            tick();
            n++;
        end
        chk("vec_reached", 32'(vec), 32'(target));
    endtask

    initial begin
        int lat, kind, s, sel, stop_at;
        logic [15:0] g, t;

        tick(); tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_truth", 32'(truth), 32'd0);
        rst = 1'b0;
        tick();

        run_sweep(0, 0, 16'h2888, 16'h0, 1'b1, lat);
        chk("ideal_latency", 32'(lat), 32'd17);
        chk("ideal_truth", 32'(truth), 32'h2888);
        chk("ideal_mm", 32'(mismatch_cnt), 32'd0);
        chk("ideal_pass", 32'(pass), 32'd1);
        chk("ideal_ffv", 32'(first_fail_vld), 32'd0);

        run_sweep(1, 0, 16'h2888, 16'h0, 1'b0, lat);
        chk("stuck_truth", 32'(truth), 32'h0000);
        chk("stuck_mm", 32'(mismatch_cnt), 32'd4);
        chk("stuck_ff", 32'(first_fail), 32'd3);
        chk("stuck_ffv", 32'(first_fail_vld), 32'd1);
        chk("stuck_pass", 32'(pass), 32'd0);

        run_sweep(2, 3, 16'h2888, 16'h0, 1'b0, lat);
        chk("delay3_latency", 32'(lat), 32'd65);
        chk("delay3_pass", 32'(pass), 32'd1);
        run_sweep(2, 0, 16'h2888, 16'h0, 1'b0, lat);
        chk("delay0_pass", 32'(pass), 32'd0);

        begin_sweep(0, 1, 16'h2888, 16'h0);
        wait_vec(4'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_truth_hi", 32'(truth[15:5]), 32'd0);
        chk("abort_truth", 32'(truth), 32'h0008);
        chk("abort_vec", 32'(vec), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end

        begin_sweep(1, 0, 16'h2888, 16'h0);
        wait_vec(4'd10);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mm", 32'(mismatch_cnt), 32'd0);
        chk("midrst_ffv", 32'(first_fail_vld), 32'd0);
        chk("midrst_vec", 32'(vec), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_sweep(0, 0, 16'h2888, 16'h0, 1'b0, lat);
        chk("post_rst_latency", 32'(lat), 32'd17);
        chk("post_rst_pass", 32'(pass), 32'd1);

        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            s    = $urandom_range(0, 3);
            t    = 16'($urandom);
            sel  = $urandom_range(0, 2);
            g    = full_truth(kind, s, t);
            if (sel == 1) g = 16'($urandom);
            if (sel == 2) g[$urandom_range(0, 15)] ^= 1'b1;
            abort = 1'(($urandom_range(0, 3) == 0));
            tick();
            abort = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                begin_sweep(kind, s, g, t);
                stop_at = $urandom_range(0, 16 * (s + 1) + 2);
                for (int i = 0; i < stop_at; i++) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                for (int i = 0; i < 3 + 16 * (s + 1); i++) tick();
            end else begin
                run_sweep(kind, s, g, t, 1'b1, lat);
                chk("rand_latency", 32'(lat), 32'(16 * (s + 1) + 1));
                tick(); tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
